// File: rtl/img2col_reader_pkg.sv
// Shared types for the im2col read stage: geometry widths, FSM encoding and coordinate helpers.
package img2col_reader_pkg;

  localparam int DIM_W   = 8;
  localparam int COORD_W = DIM_W + 2;

  typedef logic [DIM_W-1:0]          dim_t;
  typedef logic [COORD_W-1:0]        ucount_t;
  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_SETUP = 5'b00010,
    ST_RUN   = 5'b00100,
    ST_DRAIN = 5'b01000,
    ST_DONE  = 5'b10000
  } state_t;

  // Output extent along one axis; zero for an illegal span or stride so the caller never divides by zero.
  function automatic ucount_t out_dim(input dim_t in_sz, input dim_t pad_sz, input dim_t k, input dim_t s);
    int span;
    int q;
    span = int'(in_sz) + 2 * int'(pad_sz) - int'(k);
    if (s == '0 || span < 0) begin
      q = 0;
    end else begin
      q = span / int'(s) + 1;
    end
    return q[COORD_W-1:0];
  endfunction

  function automatic coord_t coord(input ucount_t o, input dim_t s, input dim_t kk, input dim_t pad_sz);
    int t;
    t = int'(o) * int'(s) + int'(kk) - int'(pad_sz);
    return $signed(t[COORD_W-1:0]);
  endfunction

  function automatic logic in_range(input coord_t v, input dim_t lim);
    return (v >= 0) && (v < $signed({2'b00, lim}));
  endfunction

endpackage

// File: rtl/img2col_reader_if.sv
// Tensor read port toward the ifmap buffer plus the patch-element stream toward the GEMM array.
interface img2col_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] tensor_addr;
  logic              t_addr_vld;
  logic [DATA_W-1:0] tensor_data;
  logic [DATA_W-1:0] col_data;
  logic              col_valid;
  logic              col_ready;
  logic              col_last;

  modport master (
    output tensor_addr, t_addr_vld, col_data, col_valid, col_last,
    input  tensor_data, col_ready
  );

  modport slave (
    input  tensor_addr, t_addr_vld, col_data, col_valid, col_last,
    output tensor_data, col_ready
  );
endinterface

// File: rtl/img2col_out_fifo.sv
// Two-entry output FIFO; the head entry drives the patch stream and reads as zero when empty.
module img2col_out_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_data [2];
  logic              mem_last [2];
  logic              rd_ptr;
  logic              wr_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_last[0] <= 1'b0;
      mem_last[1] <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_last[wr_ptr] <= push_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head_valid = (count != 2'd0);
  assign head_data  = head_valid ? mem_data[rd_ptr] : '0;
  assign head_last  = head_valid && mem_last[rd_ptr];

endmodule

// File: rtl/img2col_reader.sv
// Im2col read stage: walks output positions and patch elements, reads the ifmap buffer or inserts
// padding zeros, and streams the elements through a credit-limited two-entry FIFO.
module img2col_reader
  import img2col_reader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              conv_en,
  input  logic [ADDR_W-1:0] cfg_base,
  input  dim_t              cfg_h,
  input  dim_t              cfg_w,
  input  dim_t              cfg_c,
  input  dim_t              cfg_k,
  input  dim_t              cfg_s,
  input  dim_t              cfg_p,
  img2col_reader_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q;
  dim_t              h_q, w_q, c_q, k_q, s_q, p_q;
  ucount_t           oh_q, ow_q, oy, ox;
  dim_t              ch, ky, kx;

  logic              cfg_bad;
  coord_t            iy, ix;
  logic              pad;
  logic [ADDR_W-1:0] rd_addr;
  logic              kx_end, ky_end, ch_end, ox_end, oy_end, patch_end, last_issue;
  logic              issue, pop, push;
  logic [2:0]        occupancy;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] push_data;

  logic              s1_valid, s1_pad, s1_last, s1_held;
  logic [DATA_W-1:0] hold_data;

  assign cfg_bad = (k_q == '0) || (s_q == '0) || (c_q == '0) ||
                   ({2'b00, k_q} > ({2'b00, h_q} + {1'b0, p_q, 1'b0})) ||
                   ({2'b00, k_q} > ({2'b00, w_q} + {1'b0, p_q, 1'b0}));

  assign iy  = coord(oy, s_q, ky, p_q);
  assign ix  = coord(ox, s_q, kx, p_q);
  assign pad = !(in_range(iy, h_q) && in_range(ix, w_q));
  assign rd_addr = base_q + ADDR_W'((32'(ch) * 32'(h_q) + 32'($unsigned(iy))) * 32'(w_q)
                                    + 32'($unsigned(ix)));

  assign kx_end     = (kx == k_q - 8'd1);
  assign ky_end     = (ky == k_q - 8'd1);
  assign ch_end     = (ch == c_q - 8'd1);
  assign ox_end     = (ox == ow_q - COORD_W'(1));
  assign oy_end     = (oy == oh_q - COORD_W'(1));
  assign patch_end  = ch_end && ky_end && kx_end;
  assign last_issue = patch_end && ox_end && oy_end;

  // Credit counts the slot freed by this cycle's pop so a tied-high col_ready sustains one element per cycle.
  assign pop       = enable && bus.col_valid && bus.col_ready;
  assign push      = enable && s1_valid;
  assign occupancy = 3'(fifo_count) + 3'(s1_valid) - 3'(pop);
  assign issue     = enable && (state == ST_RUN) && (occupancy < 3'd2);

  assign bus.t_addr_vld  = issue && !pad;
  assign bus.tensor_addr = (issue && !pad) ? rd_addr : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else if (enable) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    cfg_err   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (conv_en) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        cfg_err   = cfg_bad;
        busy      = !cfg_bad;
        state_nxt = cfg_bad ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (issue && last_issue) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (occupancy == 3'd0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q <= '0;
      h_q    <= '0;
      w_q    <= '0;
      c_q    <= '0;
      k_q    <= '0;
      s_q    <= '0;
      p_q    <= '0;
      oh_q   <= '0;
      ow_q   <= '0;
      oy     <= '0;
      ox     <= '0;
      ch     <= '0;
      ky     <= '0;
      kx     <= '0;
    end else if (enable) begin
      if (state == ST_IDLE && conv_en) begin
        base_q <= cfg_base;
        h_q    <= cfg_h;
        w_q    <= cfg_w;
        c_q    <= cfg_c;
        k_q    <= cfg_k;
        s_q    <= cfg_s;
        p_q    <= cfg_p;
      end
      if (state == ST_SETUP) begin
        oh_q <= out_dim(h_q, p_q, k_q, s_q);
        ow_q <= out_dim(w_q, p_q, k_q, s_q);
        oy   <= '0;
        ox   <= '0;
        ch   <= '0;
        ky   <= '0;
        kx   <= '0;
      end
      // kx fastest, then ky, c, ox, oy; each counter clears exactly at its terminal value.
      if (issue) begin
        if (kx_end) begin
          kx <= '0;
          if (ky_end) begin
            ky <= '0;
            if (ch_end) begin
              ch <= '0;
              if (ox_end) begin
                ox <= '0;
                oy <= oy_end ? '0 : oy + COORD_W'(1);
              end else begin
                ox <= ox + COORD_W'(1);
              end
            end else begin
              ch <= ch + 8'd1;
            end
          end else begin
            ky <= ky + 8'd1;
          end
        end else begin
          kx <= kx + 8'd1;
        end
      end
    end
  end

  // The buffer answers a read even while stalled, so a landing word is parked until the stage moves again.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_pad    <= 1'b0;
      s1_last   <= 1'b0;
      s1_held   <= 1'b0;
      hold_data <= '0;
    end else if (enable) begin
      s1_valid <= issue;
      s1_pad   <= issue && pad;
      s1_last  <= issue && patch_end;
      s1_held  <= 1'b0;
    end else if (s1_valid && !s1_held) begin
      s1_held   <= 1'b1;
      hold_data <= bus.tensor_data;
    end
  end

  assign push_data = s1_pad ? '0 : (s1_held ? hold_data : bus.tensor_data);

  img2col_out_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push),
    .push_data  (push_data),
    .push_last  (s1_last),
    .pop        (pop),
    .head_valid (bus.col_valid),
    .head_data  (bus.col_data),
    .head_last  (bus.col_last),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_img2col_reader.sv
// Self-checking bench for img2col_reader: a behavioural im2col model and a RAM model drive randomized scenarios.
module tb_img2col_reader;
  import img2col_reader_pkg::*;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 20000;

  logic              clk = 1'b0;
  logic              rstn;
  logic              enable;
  logic              conv_en;
  logic [ADDR_W-1:0] cfg_base;
  dim_t              cfg_h, cfg_w, cfg_c, cfg_k, cfg_s, cfg_p;
  logic              busy, done, cfg_err;

  img2col_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  img2col_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (enable),
    .conv_en  (conv_en),
    .cfg_base (cfg_base),
    .cfg_h    (cfg_h),
    .cfg_w    (cfg_w),
    .cfg_c    (cfg_c),
    .cfg_k    (cfg_k),
    .cfg_s    (cfg_s),
    .cfg_p    (cfg_p),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  // Ifmap buffer: one-cycle read latency, garbage on cycles without a read.
  logic [DATA_W-1:0] ram [1<<ADDR_W];
  always @(posedge clk) begin
    bus.tensor_data <= bus.t_addr_vld ? ram[bus.tensor_addr] : DATA_W'($urandom);
  end

  int checks = 0;
  int passes = 0;

  logic [DATA_W-1:0] exp_data [$];
  bit                exp_last [$];
  bit                exp_pad  [$];
  int                exp_addr [$];

  logic [DATA_W-1:0] got_data [$];
  bit                got_last [$];
  int                got_addr [$];
  int done_cnt, err_cnt, busy_cnt, first_xfer, last_xfer, done_cyc, max_out, reads, acc_reads;

  task automatic build_model(input int h, w, c, k, s, p, base);
    int oh, ow, iy, ix, a;
    exp_data.delete(); exp_last.delete(); exp_pad.delete(); exp_addr.delete();
    if (k == 0 || s == 0 || c == 0 || k > h + 2*p || k > w + 2*p) return;
    oh = (h + 2*p - k) / s + 1;
    ow = (w + 2*p - k) / s + 1;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ch = 0; ch < c; ch++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              iy = oy*s + ky - p;
              ix = ox*s + kx - p;
              if (iy >= 0 && iy < h && ix >= 0 && ix < w) begin
                a = (base + (ch*h + iy)*w + ix) % (1 << ADDR_W);
                exp_addr.push_back(a);
                exp_data.push_back(ram[a]);
                exp_pad.push_back(1'b0);
              end else begin
                exp_data.push_back('0);
                exp_pad.push_back(1'b1);
              end
              exp_last.push_back(ch == c-1 && ky == k-1 && kx == k-1);
            end
  endtask

  // ready_mode: 0 tied high, 1 one-high-two-low, 2 random; en_mode: 0 tied high, 1 random drops.
  task automatic run_conv(input int h, w, c, k, s, p, base, ready_mode, en_mode, abort_at,
                          output bit timed_out);
    int cyc, tail;
    bit fin;
    got_data.delete(); got_last.delete(); got_addr.delete();
    done_cnt = 0; err_cnt = 0; busy_cnt = 0; first_xfer = -1; last_xfer = -1;
    done_cyc = -1; max_out = 0; reads = 0; acc_reads = 0;
    @(posedge clk); #1;
    cfg_base = ADDR_W'(base);
    cfg_h = dim_t'(h); cfg_w = dim_t'(w); cfg_c = dim_t'(c);
    cfg_k = dim_t'(k); cfg_s = dim_t'(s); cfg_p = dim_t'(p);
    enable = 1'b1; bus.col_ready = 1'b1; conv_en = 1'b1;
    @(posedge clk); #1;
    conv_en = 1'b0;
    cyc = 0; tail = 0; fin = 1'b0; timed_out = 1'b0;
    while (!fin) begin
      case (ready_mode)
        0:       bus.col_ready = 1'b1;
        1:       bus.col_ready = (cyc % 3 == 0);
        default: bus.col_ready = 1'($urandom_range(0, 1));
      endcase
      enable = (en_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.t_addr_vld) begin
        got_addr.push_back(int'(bus.tensor_addr));
        reads++;
      end
      if (enable && bus.col_valid && bus.col_ready) begin
        if (got_data.size() == 0) first_xfer = cyc;
        if (got_data.size() < exp_pad.size() && !exp_pad[got_data.size()]) acc_reads++;
        got_data.push_back(bus.col_data);
        got_last.push_back(bus.col_last);
        last_xfer = cyc;
      end
      if (reads - acc_reads > max_out) max_out = reads - acc_reads;
      if (busy) busy_cnt++;
      if (done && enable) begin done_cnt++; done_cyc = cyc; end
      if (cfg_err && enable) err_cnt++;
      if (tail > 0) begin
        tail--;
        if (tail == 0) fin = 1'b1;
      end else if ((done || cfg_err) && enable) begin
        tail = 3;
      end
      if (abort_at > 0 && got_data.size() == abort_at) fin = 1'b1;
      cyc++;
      if (cyc >= TIMEOUT) begin timed_out = 1'b1; fin = 1'b1; end
      @(posedge clk); #1;
    end
  endtask

  function automatic int data_diff();
    int n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++)
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) return i;
    if (got_data.size() != exp_data.size()) return n;
    return -1;
  endfunction

  function automatic int addr_diff();
    int n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++)
      if (got_addr[i] !== exp_addr[i]) return i;
    if (got_addr.size() != exp_addr.size()) return n;
    return -1;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1; conv_en = 1'b0; bus.col_ready = 1'b1;
    cfg_base = '0; cfg_h = '0; cfg_w = '0; cfg_c = '0; cfg_k = '0; cfg_s = '0; cfg_p = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.tensor_addr, bus.t_addr_vld, bus.col_data, bus.col_valid, bus.col_last} !== '0)
      $display("[TB] FAIL reset_bus: got %h required 0",
               {bus.tensor_addr, bus.t_addr_vld, bus.col_data, bus.col_valid, bus.col_last});
    else passes++;
    checks++;
    if ({busy, done, cfg_err} !== 3'b000)
      $display("[TB] FAIL reset_status: got %b required 000", {busy, done, cfg_err});
    else passes++;
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, cfg_err, bus.t_addr_vld, bus.col_valid} !== 5'b0)
      $display("[TB] FAIL idle_after_reset: got %b required 00000",
               {busy, done, cfg_err, bus.t_addr_vld, bus.col_valid});
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_valid_conv();
    bit to;
    int first_addr [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int bad, nl, badpos;
    build_model(4, 4, 1, 3, 1, 0, 0);
    run_conv(4, 4, 1, 3, 1, 0, 0, 0, 0, -1, to);
    checks++; if (to) $display("[TB] FAIL case1_timeout: got 1 required 0"); else passes++;
    checks++;
    if (got_data.size() !== 36) $display("[TB] FAIL case1_count: got %0d required 36", got_data.size());
    else passes++;
    checks++;
    if (data_diff() !== -1) $display("[TB] FAIL case1_data: first diff %0d required -1", data_diff());
    else passes++;
    bad = 0;
    for (int i = 0; i < 9; i++)
      if (i >= got_addr.size() || got_addr[i] !== first_addr[i]) bad++;
    checks++;
    if (bad !== 0) $display("[TB] FAIL case1_patch0_addr: got %0d wrong required 0", bad);
    else passes++;
    nl = 0; badpos = 0;
    foreach (got_last[i]) if (got_last[i]) begin nl++; if ((i + 1) % 9 != 0) badpos++; end
    checks++;
    if (nl !== 4 || badpos !== 0)
      $display("[TB] FAIL case1_last: got %0d lasts (%0d misplaced) required 4 (0)", nl, badpos);
    else passes++;
    checks++;
    if (done_cnt !== 1) $display("[TB] FAIL case1_done_count: got %0d required 1", done_cnt);
    else passes++;
    checks++;
    if (done_cyc !== last_xfer + 1)
      $display("[TB] FAIL case1_done_timing: got cycle %0d required %0d", done_cyc, last_xfer + 1);
    else passes++;
    checks++;
    if (last_xfer - first_xfer !== 35)
      $display("[TB] FAIL case1_throughput: got span %0d required 35", last_xfer - first_xfer);
    else passes++;
  endtask

  task automatic test_padding();
    bit to;
    logic [DATA_W-1:0] first [9];
    int bad;
    first = '{'0, '0, '0, '0, ram[0], ram[1], '0, ram[3], ram[4]};
    build_model(3, 3, 1, 3, 1, 1, 0);
    run_conv(3, 3, 1, 3, 1, 1, 0, 0, 0, -1, to);
    checks++; if (to) $display("[TB] FAIL pad_timeout: got 1 required 0"); else passes++;
    checks++;
    if (got_data.size() !== 81) $display("[TB] FAIL pad_count: got %0d required 81", got_data.size());
    else passes++;
    bad = 0;
    for (int i = 0; i < 9; i++)
      if (i >= got_data.size() || got_data[i] !== first[i]) bad++;
    checks++;
    if (bad !== 0) $display("[TB] FAIL pad_patch0: got %0d wrong required 0", bad);
    else passes++;
    checks++;
    if (data_diff() !== -1) $display("[TB] FAIL pad_data: first diff %0d required -1", data_diff());
    else passes++;
    checks++;
    if (addr_diff() !== -1)
      $display("[TB] FAIL pad_reads: first diff %0d (got %0d reads, required %0d)",
               addr_diff(), got_addr.size(), exp_addr.size());
    else passes++;
  endtask

  task automatic test_stride_channels();
    bit to;
    int p0 [8] = '{'h100, 'h101, 'h104, 'h105, 'h110, 'h111, 'h114, 'h115};
    int bad;
    build_model(4, 4, 2, 2, 2, 0, 'h100);
    run_conv(4, 4, 2, 2, 2, 0, 'h100, 0, 0, -1, to);
    checks++; if (to) $display("[TB] FAIL stride_timeout: got 1 required 0"); else passes++;
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (i >= got_addr.size() || got_addr[i] !== p0[i]) bad++;
    checks++;
    if (bad !== 0) $display("[TB] FAIL stride_patch0_addr: got %0d wrong required 0", bad);
    else passes++;
    checks++;
    if (addr_diff() !== -1) $display("[TB] FAIL stride_addr: first diff %0d required -1", addr_diff());
    else passes++;
    checks++;
    if (got_data.size() !== 32 || data_diff() !== -1)
      $display("[TB] FAIL stride_data: got %0d elems diff %0d required 32 elems diff -1",
               got_data.size(), data_diff());
    else passes++;
  endtask

  task automatic test_backpressure();
    bit to;
    for (int mode = 0; mode < 2; mode++) begin
      build_model(4, 4, 1, 3, 1, 0, 0);
      if (mode == 0) run_conv(4, 4, 1, 3, 1, 0, 0, 1, 0, -1, to);
      else           run_conv(4, 4, 1, 3, 1, 0, 0, 2, 1, -1, to);
      checks++;
      if (to || data_diff() !== -1)
        $display("[TB] FAIL bp%0d_data: timeout %0d diff %0d required 0 and -1", mode, to, data_diff());
      else passes++;
      checks++;
      if (max_out > 2) $display("[TB] FAIL bp%0d_outstanding: got %0d required <=2", mode, max_out);
      else passes++;
      checks++;
      if (done_cnt !== 1) $display("[TB] FAIL bp%0d_done: got %0d required 1", mode, done_cnt);
      else passes++;
    end
  endtask

  task automatic test_random_cfg();
    bit to;
    int h, w, c, k, s, p, base;
    for (int n = 0; n < 4; n++) begin
      do begin
        h = $urandom_range(1, 6); w = $urandom_range(1, 6); c = $urandom_range(1, 3);
        k = $urandom_range(1, 3); s = $urandom_range(1, 2); p = $urandom_range(0, 1);
      end while (k > h + 2*p || k > w + 2*p);
      base = $urandom_range(0, (1 << ADDR_W) - 1);
      build_model(h, w, c, k, s, p, base);
      run_conv(h, w, c, k, s, p, base, 2, n % 2, -1, to);
      checks++;
      if (to || data_diff() !== -1 || addr_diff() !== -1)
        $display("[TB] FAIL rand%0d_stream: timeout %0d data diff %0d addr diff %0d required 0/-1/-1",
                 n, to, data_diff(), addr_diff());
      else passes++;
      checks++;
      if (done_cnt !== 1 || max_out > 2)
        $display("[TB] FAIL rand%0d_status: done %0d outstanding %0d required 1 and <=2",
                 n, done_cnt, max_out);
      else passes++;
    end
  endtask

  task automatic test_cfg_err();
    bit to;
    build_model(4, 4, 1, 5, 1, 0, 0);
    run_conv(4, 4, 1, 5, 1, 0, 0, 0, 0, -1, to);
    checks++;
    if (to || err_cnt !== 1) $display("[TB] FAIL cfgerr_pulse: got %0d pulses required 1", err_cnt);
    else passes++;
    checks++;
    if (got_addr.size() !== 0 || got_data.size() !== 0)
      $display("[TB] FAIL cfgerr_activity: got %0d reads %0d elems required 0 0",
               got_addr.size(), got_data.size());
    else passes++;
    checks++;
    if (busy_cnt !== 0 || done_cnt !== 0)
      $display("[TB] FAIL cfgerr_busy: got busy %0d done %0d required 0 0", busy_cnt, done_cnt);
    else passes++;
  endtask

  task automatic test_abort();
    bit to;
    int done_seen;
    build_model(4, 4, 1, 3, 1, 0, 0);
    run_conv(4, 4, 1, 3, 1, 0, 0, 0, 0, 10, to);
    checks++;
    if (to || got_data.size() !== 10)
      $display("[TB] FAIL abort_reach: got %0d elems required 10", got_data.size());
    else passes++;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.tensor_addr, bus.t_addr_vld, bus.col_data, bus.col_valid, bus.col_last,
         busy, done, cfg_err} !== '0)
      $display("[TB] FAIL abort_outputs: got %h required 0",
               {bus.tensor_addr, bus.t_addr_vld, bus.col_data, bus.col_valid, bus.col_last,
                busy, done, cfg_err});
    else passes++;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    if (done) done_seen++;
    checks++;
    if (done_seen !== 0) $display("[TB] FAIL abort_no_done: got %0d required 0", done_seen);
    else passes++;
    run_conv(4, 4, 1, 3, 1, 0, 0, 0, 0, -1, to);
    checks++;
    if (got_addr.size() == 0 || got_addr[0] !== 0)
      $display("[TB] FAIL abort_restart_addr: got %0d reads, first %0d required first 0",
               got_addr.size(), (got_addr.size() == 0) ? -1 : got_addr[0]);
    else passes++;
    checks++;
    if (to || data_diff() !== -1 || done_cnt !== 1)
      $display("[TB] FAIL abort_restart_run: diff %0d done %0d required -1 and 1", data_diff(), done_cnt);
    else passes++;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'($urandom_range(1, 65535));
    $display("[TB] starting img2col_reader bench");
    test_reset();
    test_valid_conv();
    test_padding();
    test_stride_channels();
    test_backpressure();
    test_random_cfg();
    test_cfg_err();
    test_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
